maskd_pipe: RTL and testbench

//  Decodes thermometer masks back to the encoded boundary index. It is the

---
 rtl/maskd_pipe_if.sv | 29 ++
 rtl/maskd_pipe.sv | 112 +++++++++++
 tb/tb_maskd_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maskd_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maskd_pipe_if : in/out handshake bundle for the thermometer-mask decoder
// Revision 1.0
// ---------------------------------------------------------------------------
interface maskd_pipe_if #(
  parameter int W = 32
);
  localparam int XW = $clog2(W);

  logic          in_vld_i;
  logic          in_rdy_o;
  logic [W-1:0]  in_mask_i;
  logic          out_vld_o;
  logic          out_rdy_i;
  logic [XW-1:0] out_x_o;
  logic          out_err_o;

  modport slave (
    input  in_vld_i, in_mask_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_x_o, out_err_o
  );

  modport master (
    output in_vld_i, in_mask_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_x_o, out_err_o
  );
endinterface
`default_nettype wire

// File: rtl/maskd_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maskd_pipe : 2-stage valid/ready decoder from thermometer mask to index
// Revision 1.0
// ---------------------------------------------------------------------------
module maskd_pipe #(
  parameter int W              = 32,
  parameter int P_INCLUSIVE    = 1,
  parameter int LEFT_NOT_RIGHT = 0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  maskd_pipe_if.slave          bus,
  input  logic                 err_clr_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  localparam int                   XW        = $clog2(W);
  localparam logic [XW:0]          C_W_FULL  = (XW+1)'(W);
  localparam logic [XW-1:0]        C_W_MOD   = XW'(W);
  localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = '1;

  logic                 s1_vld_q;
  logic [W-1:0]         s1_mask_q;
  logic                 out_vld_q;
  logic [XW-1:0]        out_x_q;
  logic                 out_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 s2_adv;
  logic                 in_rdy;
  logic [XW:0]          s1_pop;
  logic                 s1_shape_ok;
  logic                 s1_range_ok;
  logic [XW-1:0]        s1_x_d;
  logic                 s1_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  assign s2_adv = !out_vld_q || bus.out_rdy_i;
  assign in_rdy = !s1_vld_q || s2_adv;

  always_comb begin
    s1_pop      = '0;
    s1_shape_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      s1_pop = s1_pop + (XW+1)'(s1_mask_q[i]);
    end
    // Any one followed by a zero on the fill side breaks the thermometer shape.
    for (int i = 0; i < W - 1; i++) begin
      if (LEFT_NOT_RIGHT != 0) begin
        if (s1_mask_q[i] && !s1_mask_q[i+1]) s1_shape_ok = 1'b0;
      end else begin
        if (s1_mask_q[i+1] && !s1_mask_q[i]) s1_shape_ok = 1'b0;
      end
    end

    if (P_INCLUSIVE != 0) s1_range_ok = (s1_pop != '0);
    else                  s1_range_ok = (s1_pop != C_W_FULL);

    if (LEFT_NOT_RIGHT != 0) begin
      if (P_INCLUSIVE != 0) s1_x_d = C_W_MOD - s1_pop[XW-1:0];
      else                  s1_x_d = C_W_MOD - s1_pop[XW-1:0] - XW'(1);
    end else begin
      if (P_INCLUSIVE != 0) s1_x_d = s1_pop[XW-1:0] - XW'(1);
      else                  s1_x_d = s1_pop[XW-1:0];
    end

    s1_err_d = !(s1_shape_ok && s1_range_ok);
    if (s1_err_d) s1_x_d = '0;
  end

  // Clear takes priority over a coincident counted error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (out_vld_q && bus.out_rdy_i && out_err_q && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_vld_q  <= 1'b0;
      s1_mask_q <= '0;
      out_vld_q <= 1'b0;
      out_x_q   <= '0;
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (in_rdy) begin
        s1_vld_q <= bus.in_vld_i;
        if (bus.in_vld_i) s1_mask_q <= bus.in_mask_i;
      end
      if (s2_adv) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_x_q   <= s1_x_d;
          out_err_q <= s1_err_d;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_rdy_o  = in_rdy;
  assign bus.out_vld_o = out_vld_q;
  assign bus.out_x_o   = out_x_q;
  assign bus.out_err_o = out_err_q;
  assign err_cnt_o     = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_maskd_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_maskd_pipe : directed cases plus randomized encode/decode round trips
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_maskd_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  maskd_pipe_if #(.W(8)) ifa ();
  maskd_pipe_if #(.W(8)) ifb ();
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  maskd_pipe #(.W(8), .P_INCLUSIVE(1), .LEFT_NOT_RIGHT(0), .ERR_CNT_W(2)) u_a (
    .clk(clk), .arst(rst), .bus(ifa.slave), .err_clr_i(clr_a), .err_cnt_o(cnt_a)
  );
  maskd_pipe #(.W(8), .P_INCLUSIVE(0), .LEFT_NOT_RIGHT(1), .ERR_CNT_W(8)) u_b (
    .clk(clk), .arst(rst), .bus(ifb.slave), .err_clr_i(clr_b), .err_cnt_o(cnt_b)
  );

  // Eight random instances: k<4 -> W=5 else W=16; P_INCLUSIVE=k%2; LEFT=k/2%2.
  logic [7:0]  r_vld;
  logic [7:0]  r_ordy;
  logic [15:0] r_mask [8];
  wire  [7:0]  r_irdy;
  wire  [7:0]  r_ovld;
  wire  [7:0]  r_oerr;
  wire  [3:0]  r_ox   [8];
  wire  [7:0]  r_cnt  [8];

  for (genvar k = 0; k < 8; k++) begin : g_rnd
    localparam int RW = (k < 4) ? 5 : 16;
    maskd_pipe_if #(.W(RW)) ifr ();
    assign ifr.in_vld_i  = r_vld[k];
    assign ifr.in_mask_i = r_mask[k][RW-1:0];
    assign ifr.out_rdy_i = r_ordy[k];
    assign r_irdy[k]     = ifr.in_rdy_o;
    assign r_ovld[k]     = ifr.out_vld_o;
    assign r_oerr[k]     = ifr.out_err_o;
    assign r_ox[k]       = 4'(ifr.out_x_o);
    maskd_pipe #(.W(RW), .P_INCLUSIVE(k % 2), .LEFT_NOT_RIGHT((k / 2) % 2), .ERR_CNT_W(8)) u_dut (
      .clk(clk), .arst(rst), .bus(ifr.slave), .err_clr_i(1'b0), .err_cnt_o(r_cnt[k])
    );
  end

  function automatic int kw(int k);
    return (k < 4) ? 5 : 16;
  endfunction

  // Index-to-mask generator: the reference the decoder must invert.
  function automatic logic [15:0] gen_mask(int w, int pi, int ln, int x);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < w; i++) begin
      if (ln != 0) m[i] = (pi != 0) ? (i >= x) : (i > x);
      else         m[i] = (pi != 0) ? (i <= x) : (i < x);
    end
    return m;
  endfunction

  // Legal iff some index generates exactly this mask; -1 marks an illegal beat.
  function automatic int dec_model(int w, int pi, int ln, logic [15:0] m);
    int r;
    r = -1;
    for (int x = 0; x < w; x++) begin
      if (r < 0 && gen_mask(w, pi, ln, x) == m) r = x;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One illegal beat on u_a; clr is raised in the cycle it is presented.
  task automatic a_err(input logic clr);
    ifa.in_vld_i  = 1'b1;
    ifa.in_mask_i = 8'h05;
    step();
    ifa.in_vld_i = 1'b0;
    step();
    clr_a = clr;
    step();
    clr_a = 1'b0;
    #1;
  endtask

  logic [7:0] m1 [3];
  int         x1 [3];
  logic [7:0] m3 [4];
  int         x3 [4];
  logic [7:0] m4 [4];
  int         x4 [4];

  int         qbuf [8][64];
  int         wr   [8];
  int         rd   [8];
  int         ecnt [8];
  logic [7:0] hold;
  logic [3:0] hold_x [8];
  logic [7:0] hold_e;

  initial begin
    int ni, no, first, last, e;
    r_vld  = '0;
    r_ordy = '1;
    hold   = '0;
    hold_e = '0;
    for (int k = 0; k < 8; k++) begin
      r_mask[k] = '0;
      hold_x[k] = '0;
      wr[k] = 0; rd[k] = 0; ecnt[k] = 0;
    end
    ifa.in_vld_i = 1'b0; ifa.in_mask_i = '0; ifa.out_rdy_i = 1'b1;
    ifb.in_vld_i = 1'b0; ifb.in_mask_i = '0; ifb.out_rdy_i = 1'b1;
    m1 = '{8'h07, 8'hFF, 8'h01};        x1 = '{2, 7, 0};
    m3 = '{8'h00, 8'hFE, 8'hC0, 8'h01}; x3 = '{7, 0, 5, 0};
    m4 = '{8'h01, 8'h03, 8'h0F, 8'h3F}; x4 = '{0, 1, 3, 5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld", ifa.out_vld_o, 0);
    chk("rst_x", ifa.out_x_o, 0);
    chk("rst_err", ifa.out_err_o, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_in_rdy", ifa.in_rdy_o, 1);
    step();

    // Case 1: legal inclusive right-fill masks, back to back
    for (int c = 0; c < 6; c++) begin
      ifa.in_vld_i = (c < 3);
      if (c < 3) ifa.in_mask_i = m1[c];
      #1;
      if (c >= 2 && c < 5) begin
        chk("c1_vld", ifa.out_vld_o, 1);
        chk("c1_x", ifa.out_x_o, x1[c-2]);
        chk("c1_err", ifa.out_err_o, 0);
      end else begin
        chk("c1_idle", ifa.out_vld_o, 0);
      end
      step();
    end

    // Case 2: zero mask and broken shape are both illegal
    for (int c = 0; c < 5; c++) begin
      ifa.in_vld_i  = (c < 2);
      ifa.in_mask_i = (c == 0) ? 8'h00 : 8'h05;
      #1;
      if (c == 2 || c == 3) begin
        chk("c2_vld", ifa.out_vld_o, 1);
        chk("c2_err", ifa.out_err_o, 1);
        chk("c2_x", ifa.out_x_o, 0);
      end
      if (c == 3) chk("c2_cnt_mid", cnt_a, 1);
      if (c == 4) chk("c2_cnt", cnt_a, 2);
      step();
    end

    // Case 3: exclusive left-fill decoding
    for (int c = 0; c < 7; c++) begin
      ifb.in_vld_i = (c < 4);
      if (c < 4) ifb.in_mask_i = m3[c];
      #1;
      if (c >= 2 && c < 6) begin
        chk("c3_vld", ifb.out_vld_o, 1);
        chk("c3_x", ifb.out_x_o, x3[c-2]);
        chk("c3_err", ifb.out_err_o, (c == 5) ? 1 : 0);
      end
      step();
    end

    // Case 4: back-pressure for 5 cycles while offering 4 beats
    ni = 0; no = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      ifa.in_vld_i  = (ni < 4);
      ifa.in_mask_i = m4[(ni < 4) ? ni : 3];
      ifa.out_rdy_i = (c >= 5);
      #1;
      if (c >= 2 && c < 5) begin
        chk("c4_stall_in_rdy", ifa.in_rdy_o, 0);
        chk("c4_stall_vld", ifa.out_vld_o, 1);
        chk("c4_stall_x", ifa.out_x_o, 0);
      end
      if (c == 4) chk("c4_accepted", ni, 2);
      if (ifa.out_vld_o && ifa.out_rdy_i) begin
        if (no < 4) chk("c4_order", ifa.out_x_o, x4[no]);
        else        chk("c4_extra_beat", ifa.out_vld_o, 0);
        if (first < 0) first = c;
        last = c;
        no++;
      end
      if (ifa.in_vld_i && ifa.in_rdy_o) ni++;
      step();
    end
    chk("c4_delivered", no, 4);
    chk("c4_consecutive", last - first, 3);

    // Case 5: saturation at 3 with ERR_CNT_W=2, and clear beating an increment
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    #1;
    chk("c5_clear", cnt_a, 0);
    for (int n = 1; n <= 5; n++) begin
      a_err(1'b0);
      chk("c5_sat", cnt_a, (n < 3) ? n : 3);
    end
    a_err(1'b1);
    chk("c5_clr_6th", cnt_a, 0);
    a_err(1'b0);
    chk("c5_resume", cnt_a, 1);
    a_err(1'b1);
    chk("c5_clr_wins", cnt_a, 0);

    // Case 6: asynchronous reset with both stages full
    a_err(1'b0);
    chk("c6_cnt_pre", cnt_a, 1);
    step();
    ifa.out_rdy_i = 1'b0;
    ifa.in_vld_i  = 1'b1;
    ifa.in_mask_i = 8'h03;
    step();
    ifa.in_mask_i = 8'h07;
    step();
    ifa.in_vld_i = 1'b0;
    #1;
    chk("c6_full_vld", ifa.out_vld_o, 1);
    chk("c6_full_in_rdy", ifa.in_rdy_o, 0);
    rst = 1'b1;
    #1;
    chk("c6_rst_vld", ifa.out_vld_o, 0);
    chk("c6_rst_cnt", cnt_a, 0);
    chk("c6_rst_in_rdy", ifa.in_rdy_o, 1);
    step();
    rst = 1'b0;
    ifa.out_rdy_i = 1'b1;
    ifa.in_vld_i  = 1'b1;
    ifa.in_mask_i = 8'h1F;
    #1;
    chk("c6_lat0", ifa.out_vld_o, 0);
    step();
    ifa.in_vld_i = 1'b0;
    #1;
    chk("c6_lat1", ifa.out_vld_o, 0);
    step();
    #1;
    chk("c6_lat2_vld", ifa.out_vld_o, 1);
    chk("c6_lat2_x", ifa.out_x_o, 4);
    chk("c6_lat2_err", ifa.out_err_o, 0);
    step();
    #1;
    chk("c6_dropped", ifa.out_vld_o, 0);
    step();

    // Random: mixed generated and arbitrary masks with random stalls
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 8; k++) begin
        r_vld[k] = (c < 560) && ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1)
          r_mask[k] = gen_mask(kw(k), k % 2, (k / 2) % 2, int'($urandom_range(0, kw(k) - 1)));
        else
          r_mask[k] = 16'($urandom) & 16'((1 << kw(k)) - 1);
        r_ordy[k] = (c >= 560) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < 8; k++) begin
        if (hold[k]) begin
          chk($sformatf("rnd%0d_hold_vld", k), r_ovld[k], 1);
          chk($sformatf("rnd%0d_hold_x", k), 32'(r_ox[k]), 32'(hold_x[k]));
          chk($sformatf("rnd%0d_hold_err", k), r_oerr[k], hold_e[k]);
        end
        if (r_ovld[k] && r_ordy[k]) begin
          if (rd[k] == wr[k]) begin
            chk($sformatf("rnd%0d_unexpected", k), r_ovld[k], 0);
          end else begin
            e = qbuf[k][rd[k] % 64];
            rd[k]++;
            chk($sformatf("rnd%0d_x", k), 32'(r_ox[k]), (e < 0) ? 0 : e);
            chk($sformatf("rnd%0d_err", k), r_oerr[k], (e < 0) ? 1 : 0);
            if (e < 0 && ecnt[k] < 255) ecnt[k]++;
          end
          hold[k] = 1'b0;
        end else begin
          hold[k]   = r_ovld[k];
          hold_x[k] = r_ox[k];
          hold_e[k] = r_oerr[k];
        end
        if (r_vld[k] && r_irdy[k]) begin
          qbuf[k][wr[k] % 64] = dec_model(kw(k), k % 2, (k / 2) % 2, r_mask[k]);
          wr[k]++;
        end
      end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rnd%0d_drained", k), rd[k], wr[k]);
      chk($sformatf("rnd%0d_errcnt", k), 32'(r_cnt[k]), ecnt[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
